// File: rtl/id_issue_queue.sv
// ID->issue buffer: DEPTH-entry circular FIFO of decoded scoreboard entries
// with a cap on resident control-flow entries.
module id_issue_queue #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_CF     = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         is_ctrl_flow_i,
    output logic                         valid_o,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         is_ctrl_flow_o,
    input  logic                         ack_i,
    output logic [$clog2(DEPTH):0]       usage_o,
    output logic [$clog2(MAX_CF):0]      cf_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int UW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(MAX_CF) + 1;
    localparam logic [UW-1:0] DEPTH_U = UW'(DEPTH);
    localparam logic [CW-1:0] MAX_CF_U = CW'(MAX_CF);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]      tag_q, tag_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [UW-1:0]         usage_q, usage_d;
    logic [CW-1:0]         cf_q, cf_d;
    logic                  enq, deq;

    assign valid_o        = (usage_q != '0);
    assign data_o         = mem_q[rd_ptr_q];
    assign is_ctrl_flow_o = tag_q[rd_ptr_q];
    assign usage_o        = usage_q;
    assign cf_cnt_o       = cf_q;

    assign deq = ack_i & valid_o;
    // Stall on the cf cap regardless of the incoming tag so ready has no data path.
    assign ready_o = !flush_i
                   & ((usage_q < DEPTH_U) | deq)
                   & ((cf_q < MAX_CF_U) | (deq & is_ctrl_flow_o));
    assign enq = valid_i & ready_o;

    always_comb begin
        mem_d    = mem_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usage_d  = usage_q + UW'(enq) - UW'(deq);
        cf_d     = cf_q + CW'(enq & is_ctrl_flow_i)
                        - CW'(deq & is_ctrl_flow_o);
        if (enq) begin
            mem_d[wr_ptr_q] = data_i;
            tag_d[wr_ptr_q] = is_ctrl_flow_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // Flush empties the queue but leaves storage contents in place.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usage_d  = '0;
            cf_d     = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
            cf_q     <= '0;
        end else begin
            mem_q    <= mem_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usage_q  <= usage_d;
            cf_q     <= cf_d;
        end
    end

endmodule

// File: tb/tb_id_issue_queue.sv
// Bench for id_issue_queue: queue-based reference model checked every
// falling edge, plus directed scenarios with literal expectations.
module tb_id_issue_queue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] data_i;
    logic        is_ctrl_flow_i;
    logic        valid_o;
    logic [63:0] data_o;
    logic        is_ctrl_flow_o;
    logic        ack_i;
    logic [2:0]  usage_o;
    logic [1:0]  cf_cnt_o;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] d;
        logic        cf;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] obs[$];

    id_issue_queue #(.DEPTH(4), .DATA_WIDTH(64), .MAX_CF(2)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .flush_i(flush_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i(data_i),
        .is_ctrl_flow_i(is_ctrl_flow_i),
        .valid_o(valid_o),
        .data_o(data_o),
        .is_ctrl_flow_o(is_ctrl_flow_o),
        .ack_i(ack_i),
        .usage_o(usage_o),
        .cf_cnt_o(cf_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int m_cf();
        int n = 0;
        foreach (mq[i]) if (mq[i].cf) n++;
        return n;
    endfunction

    function automatic logic m_ready();
        logic deq;
        deq = ack_i && (mq.size() > 0);
        return !flush_i
            && (mq.size() < 4 || deq)
            && (m_cf() < 2 || (deq && mq[0].cf));
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mq.delete();
        end else begin
            logic enq, deq;
            deq = ack_i && (mq.size() > 0);
            enq = valid_i && m_ready();
            if (flush_i) begin
                mq.delete();
            end else begin
                if (deq) void'(mq.pop_front());
                if (enq) mq.push_back('{d: data_i, cf: is_ctrl_flow_i});
            end
        end
    end

    always @(negedge clk_i) begin
        chk("valid_o", 64'(valid_o), 64'(mq.size() != 0));
        chk("usage_o", 64'(usage_o), 64'(mq.size()));
        chk("cf_cnt_o", 64'(cf_cnt_o), 64'(m_cf()));
        chk("ready_o", 64'(ready_o), 64'(m_ready()));
        if (mq.size() > 0) begin
            chk("data_o", data_o, mq[0].d);
            chk("cf_o", 64'(is_ctrl_flow_o), 64'(mq[0].cf));
        end
        if (!rst_i && ack_i && valid_o) obs.push_back(data_o);
    end

    task automatic drv(input logic v, input logic [63:0] d, input logic cf,
                       input logic a, input logic f);
        @(posedge clk_i);
        #1;
        valid_i        = v;
        data_i         = d;
        is_ctrl_flow_i = cf;
        ack_i          = a;
        flush_i        = f;
    endtask

    task automatic idle();
        drv(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while (mq.size() > 0 && n < 16) begin
            drv(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        idle();
        @(negedge clk_i);
        chk("drain_empty", 64'(usage_o), 64'h0);
    endtask

    initial begin
        rst_i = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        data_i = '0;
        is_ctrl_flow_i = 1'b0;
        ack_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_valid", 64'(valid_o), 64'h0);
        chk("rst_usage", 64'(usage_o), 64'h0);
        chk("rst_data", data_o, 64'h0);

        // reset mid-stream with three entries resident
        drv(1'b1, 64'h11, 1'b1, 1'b0, 1'b0);
        drv(1'b1, 64'h12, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 64'h13, 1'b0, 1'b0, 1'b0);
        idle();
        #1;
        chk("pre_rst_usage", 64'(usage_o), 64'h3);
        #1 rst_i = 1'b1;
        #1;
        chk("arst_valid", 64'(valid_o), 64'h0);
        chk("arst_usage", 64'(usage_o), 64'h0);
        chk("arst_cf", 64'(cf_cnt_o), 64'h0);
        chk("arst_data", data_o, 64'h0);
        #1 rst_i = 1'b0;
        drv(1'b1, 64'hA1, 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clk_i);
        chk("post_rst_data", data_o, 64'hA1);
        chk("post_rst_valid", 64'(valid_o), 64'h1);
        drain();

        // fill then ack while full
        for (int i = 1; i <= 4; i++) drv(1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
        drv(1'b1, 64'h5, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("full_usage", 64'(usage_o), 64'h4);
        chk("full_ready", 64'(ready_o), 64'h0);
        drv(1'b1, 64'h5, 1'b0, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("full_ack_ready", 64'(ready_o), 64'h1);
        idle();
        @(negedge clk_i);
        chk("full_ack_data", data_o, 64'h2);
        chk("full_ack_usage", 64'(usage_o), 64'h4);
        drv(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        drv(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        drv(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        idle();
        @(negedge clk_i);
        chk("tail_data", data_o, 64'h5);
        drain();

        // wrap-around stream
        obs.delete();
        for (int i = 0; i < 12; i++)
            drv(1'b1, 64'h100 + 64'(i), 1'b0, i > 0, 1'b0);
        drain();
        chk("wrap_count", 64'(obs.size()), 64'd12);
        for (int i = 0; i < 12 && i < obs.size(); i++)
            chk("wrap_order", obs[i], 64'h100 + 64'(i));

        // control-flow cap
        drv(1'b1, 64'hC1, 1'b1, 1'b0, 1'b0);
        drv(1'b1, 64'hC2, 1'b1, 1'b0, 1'b0);
        drv(1'b1, 64'hC3, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("cf_ready", 64'(ready_o), 64'h0);
        chk("cf_cnt", 64'(cf_cnt_o), 64'h2);
        chk("cf_usage", 64'(usage_o), 64'h2);
        drv(1'b1, 64'hC4, 1'b1, 1'b1, 1'b0);
        @(negedge clk_i);
        chk("cf_ack_ready", 64'(ready_o), 64'h1);
        idle();
        @(negedge clk_i);
        chk("cf_cnt_hold", 64'(cf_cnt_o), 64'h2);
        chk("cf_head", data_o, 64'hC2);
        chk("cf_usage2", 64'(usage_o), 64'h2);
        drain();

        // flush with a valid input in the same cycle
        drv(1'b1, 64'hD1, 1'b1, 1'b0, 1'b0);
        drv(1'b1, 64'hD2, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 64'hD3, 1'b0, 1'b0, 1'b0);
        drv(1'b1, 64'hD4, 1'b0, 1'b1, 1'b1);
        @(negedge clk_i);
        chk("flush_ready", 64'(ready_o), 64'h0);
        idle();
        @(negedge clk_i);
        chk("flush_valid", 64'(valid_o), 64'h0);
        chk("flush_usage", 64'(usage_o), 64'h0);
        chk("flush_cf", 64'(cf_cnt_o), 64'h0);
        drv(1'b1, 64'hE1, 1'b0, 1'b0, 1'b0);
        idle();
        @(negedge clk_i);
        chk("post_flush_data", data_o, 64'hE1);
        chk("post_flush_usage", 64'(usage_o), 64'h1);
        drain();

        // spurious ack while empty
        drv(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        drv(1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        idle();
        @(negedge clk_i);
        chk("spur_usage", 64'(usage_o), 64'h0);
        chk("spur_valid", 64'(valid_o), 64'h0);
        drv(1'b1, 64'hF1, 1'b1, 1'b0, 1'b0);
        idle();
        @(negedge clk_i);
        chk("spur_data", data_o, 64'hF1);
        chk("spur_tag", 64'(is_ctrl_flow_o), 64'h1);
        drain();

        repeat (2) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
